// File: rtl/instr_mem_responder_pkg.sv
// Shared types for the instruction-memory responder: FSM state encoding,
// response-pipeline entry layout and small helpers.
package instr_mem_responder_pkg;

    // Word-index field width carried through the response pipeline
    localparam int unsigned RESP_IDX_W  = 30;
    // Outstanding counter width (limit is at most 8)
    localparam int unsigned OUT_CNT_W   = 4;
    // Stall counter width (grant delay is at most 15)
    localparam int unsigned STALL_CNT_W = 4;
    // Statistics counter width
    localparam int unsigned STAT_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } imr_state_e;

    // One accepted fetch travelling towards its rvalid cycle
    typedef struct packed {
        logic                  valid;
        logic [RESP_IDX_W-1:0] idx;
        logic                  oor;
    } resp_entry_t;

    // Increment that sticks at all-ones
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/instr_resp_pipe.sv
// Fixed-latency delay line for accepted fetches. o_head_c is the entry that
// becomes the registered response on the next clock edge, so the top can
// register rdata/err together with rvalid.
module instr_resp_pipe
    import instr_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  resp_entry_t i_push,
    output resp_entry_t o_head_c
);

    if (LATENCY <= 1) begin : g_direct
        // Accepted entry feeds the output register directly
        logic w_unused_ok;
        assign w_unused_ok = clk ^ rst;
        assign o_head_c    = i_push;
    end else begin : g_stages
        resp_entry_t r_stage [LATENCY-1];

        // Shift accepted entries one stage per cycle; reset drops all in-flight fetches
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_push;
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_head_c = r_stage[LATENCY-2];
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: grants core fetches after a configurable
// delay, limits outstanding fetches and returns words after a fixed latency.
// Optional counters: define INSTR_MEM_STATS_EN to add stat_grants and
// stat_stall_cycles.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RVALID_LATENCY  = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_grant,
    output logic                  instr_rvalid,
    output logic [DATA_WIDTH-1:0] instr_rdata,
    output logic                  instr_err,
`ifdef INSTR_MEM_STATS_EN
    output logic [STAT_W-1:0]     stat_grants,
    output logic [STAT_W-1:0]     stat_stall_cycles,
`endif
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    imr_state_e              r_state;
    imr_state_e              w_state_eff;
    imr_state_e              w_state_next;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;
    logic [STALL_CNT_W-1:0]  w_stall_cnt_next;
    logic [OUT_CNT_W-1:0]    r_outstanding;
    logic [OUT_CNT_W-1:0]    w_out_live;
    logic                    w_grant;
    logic                    w_accept;

    logic [WIDX_W-1:0]       w_req_idx;
    logic [WIDX_W-1:0]       w_load_idx;
    logic                    w_req_oor;
    logic                    w_load_oor;
    logic                    w_load_hit;
    logic [DATA_WIDTH-1:0]   w_head_word;

    resp_entry_t             w_push;
    resp_entry_t             w_head;

    logic                    r_rvalid;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_unused_ok;

    // Word indices; the byte-offset bits never select anything
    assign w_req_idx   = instr_addr[ADDR_WIDTH-1:2];
    assign w_load_idx  = load_addr[ADDR_WIDTH-1:2];
    assign w_req_oor   = 64'(w_req_idx) >= 64'(MEM_DEPTH);
    assign w_load_oor  = 64'(w_load_idx) >= 64'(MEM_DEPTH);
    assign w_unused_ok = ^{instr_addr[1:0], load_addr[1:0], w_head.idx};

    // A response retiring this cycle frees its slot for a grant in the same cycle
    assign w_out_live = r_outstanding - OUT_CNT_W'(r_rvalid);

    // FSM next state and grant. The IDLE->GRANT and STALL->GRANT moves take
    // effect in the cycle they are decided so the grant lands exactly
    // GNT_DELAY cycles after the request is first seen.
    always_comb begin
        w_state_eff      = ST_IDLE;
        w_state_next     = ST_IDLE;
        w_stall_cnt_next = '0;
        w_grant          = 1'b0;
        if (instr_req) begin
            case (r_state)
                ST_IDLE:  w_state_eff = (GNT_DELAY == 0) ? ST_GRANT : ST_STALL;
                ST_STALL: w_state_eff = (r_stall_cnt == STALL_CNT_W'(GNT_DELAY)) ? ST_GRANT : ST_STALL;
                ST_GRANT: w_state_eff = ST_GRANT;
                default:  w_state_eff = ST_IDLE;
            endcase
        end
        w_grant = (w_state_eff == ST_GRANT) && !rst
                  && (w_out_live < OUT_CNT_W'(MAX_OUTSTANDING));
        case (w_state_eff)
            ST_STALL: begin
                w_state_next     = ST_STALL;
                w_stall_cnt_next = (r_state == ST_STALL) ? r_stall_cnt + STALL_CNT_W'(1)
                                                         : STALL_CNT_W'(1);
            end
            ST_GRANT: w_state_next = w_grant ? ST_IDLE : ST_GRANT;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_accept    = w_grant;
    assign instr_grant = w_grant;

    // FSM state and stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_cnt_next;
        end
    end

    // Entry captured at acceptance; out-of-range fetches carry no index
    always_comb begin
        w_push       = '0;
        w_push.valid = w_accept;
        w_push.oor   = w_req_oor;
        w_push.idx   = w_req_oor ? '0 : RESP_IDX_W'(w_req_idx[MEM_AW-1:0]);
    end

    instr_resp_pipe #(
        .LATENCY (RVALID_LATENCY)
    ) u_resp_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .o_head_c (w_head)
    );

    // Word for the response; a load on the same edge wins over the stored word
    assign w_load_hit  = load_en && !w_load_oor
                         && (w_load_idx[MEM_AW-1:0] == w_head.idx[MEM_AW-1:0]);
    assign w_head_word = w_load_hit ? load_data : r_mem[w_head.idx[MEM_AW-1:0]];

    // Outstanding count and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_rvalid      <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_outstanding <= r_outstanding + OUT_CNT_W'(w_accept) - OUT_CNT_W'(r_rvalid);
            r_rvalid      <= w_head.valid;
            r_err         <= w_head.valid && w_head.oor;
            r_rdata       <= (w_head.valid && !w_head.oor) ? w_head_word : '0;
        end
    end

    // Preload port; memory contents survive reset, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (load_en && !w_load_oor) begin
            r_mem[w_load_idx[MEM_AW-1:0]] <= load_data;
        end
    end

    assign instr_rvalid = r_rvalid;
    assign instr_rdata  = r_rdata;
    assign instr_err    = r_err;

`ifdef INSTR_MEM_STATS_EN
    logic [STAT_W-1:0] r_stat_grants;
    logic [STAT_W-1:0] r_stat_stall;

    // Grant and stall-cycle counters, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_grants <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_accept) begin
                r_stat_grants <= sat_inc(r_stat_grants);
            end
            if ((w_state_eff == ST_GRANT || w_state_eff == ST_STALL) && instr_req && !w_grant) begin
                r_stat_stall <= sat_inc(r_stat_stall);
            end
        end
    end

    assign stat_grants       = r_stat_grants;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder. Four instances share clock, reset
// and the preload port: 0 = defaults, 1 = GNT_DELAY 3, 2 = RVALID_LATENCY 4,
// 3 = RVALID_LATENCY 3.
module tb_instr_mem_responder;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        ld;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        req   [4];
    logic [31:0] addr  [4];
    logic        gnt   [4];
    logic        rv    [4];
    logic [31:0] rdata [4];
    logic        err   [4];
`ifdef INSTR_MEM_STATS_EN
    logic [31:0] sg [4];
    logic [31:0] ss [4];
`endif

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl [13];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        instr_mem_responder #(
            .ADDR_WIDTH      (32),
            .DATA_WIDTH      (32),
            .MEM_DEPTH       (1024),
            .GNT_DELAY       ((g == 1) ? 3 : 0),
            .RVALID_LATENCY  ((g == 2) ? 4 : ((g == 3) ? 3 : 1)),
            .MAX_OUTSTANDING (2)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .instr_req         (req[g]),
            .instr_addr        (addr[g]),
            .instr_grant       (gnt[g]),
            .instr_rvalid      (rv[g]),
            .instr_rdata       (rdata[g]),
            .instr_err         (err[g]),
`ifdef INSTR_MEM_STATS_EN
            .stat_grants       (sg[g]),
            .stat_stall_cycles (ss[g]),
`endif
            .load_en           (load_en),
            .load_addr         (load_addr),
            .load_data         (load_data)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input int d, input string nm, input logic g, input logic v,
                            input logic [31:0] dat, input logic e);
        chk($sformatf("%s u%0d grant", nm, d), 32'(gnt[d]), 32'(g));
        chk($sformatf("%s u%0d rvalid", nm, d), 32'(rv[d]), 32'(v));
        chk($sformatf("%s u%0d rdata", nm, d), rdata[d], dat);
        chk($sformatf("%s u%0d err", nm, d), 32'(err[d]), 32'(e));
    endtask

    initial begin
        // req, addr, ld, ld_addr, ld_data, exp grant, exp rvalid, exp rdata, exp err
        tbl[0]  = '{1'b1, 32'h10,   1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h13,   1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h14,   1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 32'h1000, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h12345678, 1'b0};
        tbl[5]  = '{1'b1, 32'hFFC,  1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
        tbl[6]  = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 1'b0};
        tbl[7]  = '{1'b1, 32'h8,    1'b1, 32'h8,    32'h5A5A5A5A, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h5A5A5A5A, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,    1'b1, 32'h1000, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'h0,    1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h11111111, 1'b0};
        tbl[12] = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,        1'b0};

        // Reset with requests pending: nothing may be granted or returned
        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]  = 1'b1;
            addr[i] = 32'h10;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk_resp(i, "reset", 1'b0, 1'b0, 32'h0, 1'b0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req[i] = 1'b0;

        // Preload words 0, 4, 5 and 1023
        load_en = 1'b1;
        load_addr = 32'h0;   load_data = 32'h11111111; cyc();
        load_addr = 32'h10;  load_data = 32'hDEADBEEF; cyc();
        load_addr = 32'h14;  load_data = 32'h12345678; cyc();
        load_addr = 32'hFFC; load_data = 32'hCAFEF00D; cyc();
        load_en = 1'b0;

        // Default configuration, one table row per cycle
        for (int i = 0; i < 13; i++) begin
            req[0]    = tbl[i].req;
            addr[0]   = tbl[i].addr;
            load_en   = tbl[i].ld;
            load_addr = tbl[i].ld_addr;
            load_data = tbl[i].ld_data;
            @(negedge clk);
            chk_resp(0, $sformatf("row%0d", i), tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].err);
            cyc();
        end
        req[0]  = 1'b0;
        load_en = 1'b0;

        // Grant delay 3 with req held at 0x0
        req[1]  = 1'b1;
        addr[1] = 32'h0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req[1] = 1'b0;
            @(negedge clk);
            chk($sformatf("delay3 c%0d grant", k), 32'(gnt[1]), 32'(k == 3));
            chk($sformatf("delay3 c%0d rvalid", k), 32'(rv[1]), 32'(k == 4));
            chk($sformatf("delay3 c%0d rdata", k), rdata[1], (k == 4) ? 32'h11111111 : 32'h0);
            cyc();
        end

        // Request dropped mid-stall is discarded and the delay restarts
        for (int k = 0; k < 8; k++) begin
            req[1] = (k != 2) && (k < 7);
            @(negedge clk);
            chk($sformatf("drop c%0d grant", k), 32'(gnt[1]), 32'(k == 6));
            chk($sformatf("drop c%0d rvalid", k), 32'(rv[1]), 32'(k == 7));
            cyc();
        end
        req[1] = 1'b0;

        // Two-deep outstanding limit, latency 4, req held for five cycles
        addr[2] = 32'h10;
        for (int k = 0; k < 9; k++) begin
            req[2] = (k <= 4);
            @(negedge clk);
            chk($sformatf("limit c%0d grant", k), 32'(gnt[2]), 32'(k == 0 || k == 1 || k == 4));
            chk($sformatf("limit c%0d rvalid", k), 32'(rv[2]), 32'(k == 4 || k == 5 || k == 8));
            chk($sformatf("limit c%0d rdata", k), rdata[2],
                (k == 4 || k == 5 || k == 8) ? 32'hDEADBEEF : 32'h0);
            cyc();
        end
        req[2] = 1'b0;

        // Reset one cycle after a grant drops the in-flight response
        req[3]  = 1'b1;
        addr[3] = 32'h10;
        @(negedge clk);
        chk("flush c0 grant", 32'(gnt[3]), 32'h1);
        cyc();
        req[3] = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk_resp(3, "flush c1", 1'b0, 1'b0, 32'h0, 1'b0);
        cyc();
        rst = 1'b0;
        for (int k = 2; k < 7; k++) begin
            @(negedge clk);
            chk_resp(3, $sformatf("flush c%0d", k), 1'b0, 1'b0, 32'h0, 1'b0);
            cyc();
        end

        // Memory contents survive reset
        req[0]  = 1'b1;
        addr[0] = 32'h10;
        @(negedge clk);
        chk("post-reset grant", 32'(gnt[0]), 32'h1);
        cyc();
        req[0] = 1'b0;
        @(negedge clk);
        chk_resp(0, "post-reset", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
